adv_timer_b_cnt_ctrl: RTL and testbench

//  Command sequencer for the advanced-timer counter datapath. Accepts START/STOP/ARM/RESET/UPDATE

---
 rtl/adv_timer_b_cnt_ctrl_pkg.sv | 51 +++++
 rtl/adv_timer_b_psc.sv | 45 ++++
 rtl/adv_timer_b_cnt_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_adv_timer_b_cnt_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adv_timer_b_cnt_ctrl_pkg.sv
// Package: adv_timer_b_cnt_ctrl_pkg
// Shared types for the advanced-timer counter sequencer: command opcodes, counting modes,
// FSM states and the double-buffered configuration record with its reset value.
package adv_timer_b_cnt_ctrl_pkg;

   // Widths of the configuration record; the top-level parameters default to these.
   localparam int unsigned CFG_CNT_W = 16;
   localparam int unsigned CFG_PSC_W = 8;

   typedef enum logic [2:0] {
      CmdNop    = 3'd0,
      CmdStart  = 3'd1,
      CmdStop   = 3'd2,
      CmdArm    = 3'd3,
      CmdReset  = 3'd4,
      CmdUpdate = 3'd5
   } cmd_e;

   typedef enum logic [1:0] {
      ModeSawUp   = 2'd0,
      ModeSawDown = 2'd1,
      ModeUpDown  = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StRun   = 2'd2
   } state_e;

   typedef struct packed {
      logic [CFG_CNT_W-1:0] start_val;
      logic [CFG_CNT_W-1:0] end_val;
      logic [CFG_PSC_W-1:0] psc;
      mode_e                mode;
   } cfg_t;

   localparam cfg_t CFG_RST = '{start_val: '0, end_val: '1, psc: '0, mode: ModeSawUp};

   // Encoding 3 is reserved and behaves as SAW_UP.
   function automatic mode_e norm_mode(logic [1:0] m);
      mode_e r;
      case (m)
         2'd1:    r = ModeSawDown;
         2'd2:    r = ModeUpDown;
         default: r = ModeSawUp;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/adv_timer_b_psc.sv
// Module: adv_timer_b_psc
// Prescaler for the counter sequencer. Counts 0..psc while enabled and flags the wrap cycle.
// Ports:
//   clk_i   clock
//   rst_i   synchronous reset, active high
//   clr_i   force the count back to zero
//   en_i    count enable
//   psc_i   prescale value (tick every psc+1 enabled cycles)
//   tick_o  high in the enabled cycle where the count reaches psc
module adv_timer_b_psc
   import adv_timer_b_cnt_ctrl_pkg::*;
#(
   parameter int unsigned PSC_W = CFG_PSC_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [PSC_W-1:0] psc_i,
   output logic             tick_o
);

   logic [PSC_W-1:0] cnt_q, cnt_d;

   // >= keeps the count from running away if psc ever shrinks below the current count.
   assign tick_o = en_i && (cnt_q >= psc_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adv_timer_b_cnt_ctrl.sv
// Module: adv_timer_b_cnt_ctrl
// Command sequencer for the advanced-timer counter datapath. Accepts START/STOP/ARM/RESET/UPDATE
// over a valid/ready port, runs the prescaler and drives the external counter's step/load/dir
// controls. Configuration is double-buffered (shadow -> active) so updates land on end events.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_op_i                     command opcode (cmd_e; 6-7 are NOP)
//   cfg_start_i/end_i/psc_i/mode_i  UPDATE payload
//   ext_trig_i                   external trigger, leaves ARMED on a rising edge
//   cnt_i                        current counter value from the datapath
//   cnt_en_o, cnt_dir_o          step strobe and direction (1 = down)
//   cnt_load_o, cnt_load_val_o   load strobe and value
//   end_evt_o                    wrap / turnaround pulse
//   err_o                        UPDATE rejected pulse
//   state_o, upd_pend_o          FSM state, shadow config awaiting transfer
module adv_timer_b_cnt_ctrl
   import adv_timer_b_cnt_ctrl_pkg::*;
#(
   // cfg_t is sized by the package; keep these at their defaults.
   parameter int unsigned CNT_W = CFG_CNT_W,
   parameter int unsigned PSC_W = CFG_PSC_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [2:0]       cmd_op_i,
   input  logic [CNT_W-1:0] cfg_start_i,
   input  logic [CNT_W-1:0] cfg_end_i,
   input  logic [PSC_W-1:0] cfg_psc_i,
   input  logic [1:0]       cfg_mode_i,
   input  logic             ext_trig_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             cnt_en_o,
   output logic             cnt_dir_o,
   output logic             cnt_load_o,
   output logic [CNT_W-1:0] cnt_load_val_o,
   output logic             end_evt_o,
   output logic             err_o,
   output logic [1:0]       state_o,
   output logic             upd_pend_o
);

   state_e           state_q, state_d;
   cfg_t             active_q, active_d, shadow_q, shadow_d;
   logic             upd_pend_q, upd_pend_d;
   logic             dir_q, dir_d;
   logic             load_q, load_d;
   logic [CNT_W-1:0] load_val_q, load_val_d;
   logic             err_q, err_d;
   logic             trig_prev_q, cmd_ready_q;

   logic             accept, is_start, is_stop, is_arm, is_reset, is_update, upd_ok;
   logic             trig_edge, updown, term, end_evt, saw_wrap, wrap_load, transfer, do_load;
   logic             psc_en, psc_clr, psc_tick;
   logic [CNT_W-1:0] wrap_val, init_val;

   // The load cycle is not a count cycle, so the prescaler pauses while a load is presented.
   assign psc_en = (state_q == StRun) && !load_q;

   adv_timer_b_psc #(
      .PSC_W (PSC_W)
   ) u_psc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (psc_clr),
      .en_i   (psc_en),
      .psc_i  (active_q.psc),
      .tick_o (psc_tick)
   );

   // Command decode and terminal detect.
   always_comb begin
      accept    = cmd_valid_i && cmd_ready_q;
      is_start  = accept && (cmd_op_i == CmdStart);
      is_stop   = accept && (cmd_op_i == CmdStop);
      is_arm    = accept && (cmd_op_i == CmdArm);
      is_reset  = accept && (cmd_op_i == CmdReset);
      is_update = accept && (cmd_op_i == CmdUpdate);
      upd_ok    = is_update && (cfg_start_i < cfg_end_i);
      trig_edge = ext_trig_i && !trig_prev_q;
      updown    = (active_q.mode == ModeUpDown);

      case (active_q.mode)
         ModeSawDown: term = (cnt_i == active_q.start_val);
         // Only the bound being approached counts, so the start value is not a turnaround
         // on the way up.
         ModeUpDown:  term = dir_q ? (cnt_i == active_q.start_val) : (cnt_i == active_q.end_val);
         default:     term = (cnt_i == active_q.end_val);
      endcase

      end_evt  = psc_tick && term;
      saw_wrap = end_evt && !updown;
      // STOP/RESET accepted in the wrap cycle cancel the wrap load; the event still fires.
      wrap_load = saw_wrap && !(is_stop || is_reset);
      wrap_val  = (active_q.mode == ModeSawDown) ? active_q.end_val : active_q.start_val;
   end

   assign cnt_en_o       = psc_tick && !saw_wrap;
   assign cnt_load_o     = load_q || wrap_load;
   assign cnt_load_val_o = load_q ? load_val_q : (wrap_load ? wrap_val : '0);
   assign end_evt_o      = end_evt;
   assign err_o          = err_q;
   assign state_o        = state_q;
   assign upd_pend_o     = upd_pend_q;
   assign cmd_ready_o    = cmd_ready_q;

   // The turnaround step already moves in the new direction.
   always_comb begin
      case (active_q.mode)
         ModeSawDown: cnt_dir_o = 1'b1;
         ModeUpDown:  cnt_dir_o = end_evt ? !dir_q : dir_q;
         default:     cnt_dir_o = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      shadow_d   = shadow_q;
      upd_pend_d = upd_pend_q;
      dir_d      = dir_q;
      load_d     = 1'b0;
      load_val_d = load_val_q;
      psc_clr    = 1'b0;
      do_load    = 1'b0;
      err_d      = is_update && !upd_ok;

      // The wrap load above reads active_q, so a transfer here takes effect next cycle.
      transfer = upd_pend_q && (end_evt || (state_q == StIdle));
      if (transfer) begin
         active_d   = shadow_q;
         upd_pend_d = 1'b0;
      end
      if (upd_ok) begin
         shadow_d   = '{start_val: cfg_start_i, end_val: cfg_end_i, psc: cfg_psc_i,
                        mode: norm_mode(cfg_mode_i)};
         upd_pend_d = 1'b1;
      end

      if (end_evt && updown) begin
         dir_d = !dir_q;
      end

      case (state_q)
         StIdle: begin
            if (is_start) begin
               state_d = StRun;
               do_load = 1'b1;
            end else if (is_arm) begin
               state_d = StArmed;
            end
         end
         StArmed: begin
            if (is_stop) begin
               state_d = StIdle;
            end else if (trig_edge) begin
               state_d = StRun;
               do_load = 1'b1;
            end
         end
         StRun: begin
            if (is_stop) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (is_reset) begin
         do_load = 1'b1;
      end

      // Loads use active_d so a config transferring this cycle is the one started with.
      init_val = (active_d.mode == ModeSawDown) ? active_d.end_val : active_d.start_val;
      if (do_load) begin
         load_d     = 1'b1;
         load_val_d = init_val;
         psc_clr    = 1'b1;
         dir_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         active_q    <= CFG_RST;
         shadow_q    <= CFG_RST;
         upd_pend_q  <= 1'b0;
         dir_q       <= 1'b0;
         load_q      <= 1'b0;
         load_val_q  <= '0;
         err_q       <= 1'b0;
         trig_prev_q <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         shadow_q    <= shadow_d;
         upd_pend_q  <= upd_pend_d;
         dir_q       <= dir_d;
         load_q      <= load_d;
         load_val_q  <= load_val_d;
         err_q       <= err_d;
         trig_prev_q <= ext_trig_i;
         cmd_ready_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adv_timer_b_cnt_ctrl.sv
// Directed bench for adv_timer_b_cnt_ctrl with a behavioural counter datapath on cnt_i.
module tb_adv_timer_b_cnt_ctrl;

   localparam int unsigned CW = 16;
   localparam int unsigned PW = 8;

   localparam logic [2:0] OP_START = 3'd1;
   localparam logic [2:0] OP_STOP  = 3'd2;
   localparam logic [2:0] OP_ARM   = 3'd3;
   localparam logic [2:0] OP_RESET = 3'd4;
   localparam logic [2:0] OP_UPD   = 3'd5;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [CW-1:0] cfg_start, cfg_end;
   logic [PW-1:0] cfg_psc;
   logic [1:0]    cfg_mode;
   logic          ext_trig;
   logic [CW-1:0] cnt;
   logic          cnt_en, cnt_dir, cnt_load, end_evt, err;
   logic [CW-1:0] cnt_load_val;
   logic [1:0]    state;
   logic          upd_pend;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adv_timer_b_cnt_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cmd_valid_i    (cmd_valid),
      .cmd_ready_o    (cmd_ready),
      .cmd_op_i       (cmd_op),
      .cfg_start_i    (cfg_start),
      .cfg_end_i      (cfg_end),
      .cfg_psc_i      (cfg_psc),
      .cfg_mode_i     (cfg_mode),
      .ext_trig_i     (ext_trig),
      .cnt_i          (cnt),
      .cnt_en_o       (cnt_en),
      .cnt_dir_o      (cnt_dir),
      .cnt_load_o     (cnt_load),
      .cnt_load_val_o (cnt_load_val),
      .end_evt_o      (end_evt),
      .err_o          (err),
      .state_o        (state),
      .upd_pend_o     (upd_pend)
   );

   // Counter datapath model.
   always @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (cnt_load) cnt <= cnt_load_val;
      else if (cnt_en) cnt <= cnt_dir ? cnt - 16'd1 : cnt + 16'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [CW-1:0] s, input logic [CW-1:0] e,
                        input logic [PW-1:0] p, input logic [1:0] m);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cfg_start = s;
      cfg_end   = e;
      cfg_psc   = p;
      cfg_mode  = m;
   endtask

   task automatic idle();
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
   endtask

   initial begin
      int n_load;
      rst = 1'b1;
      ext_trig = 1'b0;
      cfg_start = '0; cfg_end = '0; cfg_psc = '0; cfg_mode = '0;
      idle();
      repeat (2) nxt();
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_ready", 32'(cmd_ready), 0);
      check("rst_load", 32'(cnt_load), 0);
      check("rst_load_val", 32'(cnt_load_val), 0);
      check("rst_en", 32'(cnt_en), 0);
      check("rst_dir", 32'(cnt_dir), 0);
      check("rst_pend", 32'(upd_pend), 0);
      rst = 1'b0;
      nxt();
      check("ready_after_rst", 32'(cmd_ready), 1);

      // 1: SAW_UP 2..5, psc 0.
      for (int c = 0; c <= 12; c++) begin
         idle();
         if (c == 0) drive(OP_UPD, 16'd2, 16'd5, 8'd0, 2'd0);
         if (c == 1) drive(OP_START, '0, '0, '0, '0);
         if (c == 11) drive(OP_STOP, '0, '0, '0, '0);
         #1;
         if (c == 1) check("t1_pend", 32'(upd_pend), 1);
         if (c == 2) begin
            check("t1_state", 32'(state), 2);
            check("t1_load_val", 32'(cnt_load_val), 2);
         end
         if (c >= 2 && c <= 11) begin
            check("t1_load", 32'(cnt_load), 32'(c == 2 || c == 6 || c == 10));
            check("t1_en", 32'(cnt_en), 32'(!(c == 2 || c == 6 || c == 10)));
            check("t1_evt", 32'(end_evt), 32'(c == 6 || c == 10));
         end
         if (c >= 3 && c <= 11) check("t1_cnt", 32'(cnt), 2 + ((c - 3) % 4));
         if (c == 6) check("t1_wrap_val", 32'(cnt_load_val), 2);
         if (c == 12) begin
            check("t1_stop_state", 32'(state), 0);
            check("t1_stop_load", 32'(cnt_load), 0);
         end
         nxt();
      end

      // 2: UPDOWN 0..3, psc 3.
      for (int d = 0; d <= 36; d++) begin
         int j;
         j = d - 2;
         idle();
         if (d == 0) drive(OP_UPD, 16'd0, 16'd3, 8'd3, 2'd2);
         if (d == 1) drive(OP_START, '0, '0, '0, '0);
         if (j == 33) drive(OP_STOP, '0, '0, '0, '0);
         #1;
         if (j >= 0 && j <= 32) begin
            check("t2_load", 32'(cnt_load), 32'(j == 0));
            check("t2_en", 32'(cnt_en), 32'(j > 0 && (j % 4) == 0));
            check("t2_evt", 32'(end_evt), 32'(j == 16 || j == 28));
            check("t2_dir", 32'(cnt_dir), 32'(j >= 16 && j < 28));
         end
         if (j == 16) check("t2_cnt_top", 32'(cnt), 3);
         if (j == 28) check("t2_cnt_bot", 32'(cnt), 0);
         if (j == 34) check("t2_stop_state", 32'(state), 0);
         nxt();
      end

      // 3: UPDATE mid-period, transfer at the wrap; STOP coinciding with a wrap.
      for (int e = 0; e <= 24; e++) begin
         int i;
         i = e - 2;
         idle();
         if (e == 0) drive(OP_UPD, 16'd2, 16'd5, 8'd0, 2'd0);
         if (e == 1) drive(OP_START, '0, '0, '0, '0);
         if (i == 1) drive(OP_UPD, 16'd1, 16'd9, 8'd0, 2'd0);
         if (i == 21) drive(OP_STOP, '0, '0, '0, '0);
         #1;
         if (i == 0) check("t3_load_val", 32'(cnt_load_val), 2);
         if (i == 1) check("t3_pend0", 32'(upd_pend), 0);
         if (i == 2) check("t3_pend1", 32'(upd_pend), 1);
         if (i == 4) begin
            check("t3_evt_old", 32'(end_evt), 1);
            check("t3_wrap_old_start", 32'(cnt_load_val), 2);
            check("t3_pend_at_evt", 32'(upd_pend), 1);
         end
         if (i == 5) check("t3_pend_clr", 32'(upd_pend), 0);
         if (i == 8) begin
            check("t3_cnt5", 32'(cnt), 5);
            check("t3_no_evt5", 32'(end_evt), 0);
            check("t3_en5", 32'(cnt_en), 1);
         end
         if (i == 12) begin
            check("t3_cnt9", 32'(cnt), 9);
            check("t3_evt_new", 32'(end_evt), 1);
            check("t3_wrap_new_start", 32'(cnt_load_val), 1);
         end
         if (i == 21) begin
            check("t3_ovr_cnt", 32'(cnt), 9);
            check("t3_ovr_evt", 32'(end_evt), 1);
            check("t3_ovr_load", 32'(cnt_load), 0);
            check("t3_ovr_en", 32'(cnt_en), 0);
         end
         if (i == 22) begin
            check("t3_ovr_state", 32'(state), 0);
            check("t3_ovr_load2", 32'(cnt_load), 0);
         end
         nxt();
      end

      // 4: ARM with a held trigger; STOP beats a simultaneous edge.
      n_load = 0;
      for (int k = 0; k <= 9; k++) begin
         idle();
         ext_trig = (k >= 1 && k <= 3) || (k >= 7 && k <= 8);
         if (k == 0 || k == 6) drive(OP_ARM, '0, '0, '0, '0);
         if (k == 5 || k == 7) drive(OP_STOP, '0, '0, '0, '0);
         #1;
         if (k >= 2 && k <= 4 && cnt_load) n_load++;
         if (k == 1) check("t4_armed", 32'(state), 1);
         if (k == 2) begin
            check("t4_trig_state", 32'(state), 2);
            check("t4_trig_load_val", 32'(cnt_load_val), 1);
         end
         if (k == 5) check("t4_one_load", 32'(n_load), 1);
         if (k == 6) check("t4_stop_state", 32'(state), 0);
         if (k == 7) begin
            check("t4_rearmed", 32'(state), 1);
            check("t4_edge_stop_load", 32'(cnt_load), 0);
         end
         if (k == 8 || k == 9) begin
            check("t4_stop_wins_state", 32'(state), 0);
            check("t4_stop_wins_load", 32'(cnt_load), 0);
         end
         nxt();
      end
      ext_trig = 1'b0;

      // 5 and 6: rejected UPDATEs, RESET command, then rst_i in RUN with a pending shadow.
      for (int m = 0; m <= 13; m++) begin
         idle();
         rst = (m == 8);
         if (m == 0) drive(OP_UPD, 16'd7, 16'd7, 8'd5, 2'd1);
         if (m == 1) drive(OP_UPD, 16'd8, 16'd4, 8'd0, 2'd0);
         if (m == 3) drive(OP_START, '0, '0, '0, '0);
         if (m == 5) drive(OP_UPD, 16'd3, 16'd6, 8'd1, 2'd1);
         if (m == 6) drive(OP_RESET, '0, '0, '0, '0);
         if (m == 10) drive(OP_START, '0, '0, '0, '0);
         if (m == 12) drive(OP_STOP, '0, '0, '0, '0);
         #1;
         if (m == 1 || m == 2) begin
            check("t5_err", 32'(err), 1);
            check("t5_no_pend", 32'(upd_pend), 0);
         end
         if (m == 3) check("t5_err_clr", 32'(err), 0);
         if (m == 4) begin
            check("t5_start_state", 32'(state), 2);
            check("t5_shadow_kept", 32'(cnt_load_val), 1);
         end
         if (m == 6) check("t6_pend", 32'(upd_pend), 1);
         if (m == 7) begin
            check("t6_rcmd_load", 32'(cnt_load), 1);
            check("t6_rcmd_val", 32'(cnt_load_val), 1);
            check("t6_rcmd_state", 32'(state), 2);
         end
         if (m == 9) begin
            check("t6_rst_state", 32'(state), 0);
            check("t6_rst_ready", 32'(cmd_ready), 0);
            check("t6_rst_pend", 32'(upd_pend), 0);
            check("t6_rst_load", 32'(cnt_load), 0);
            check("t6_rst_en", 32'(cnt_en), 0);
            check("t6_rst_val", 32'(cnt_load_val), 0);
         end
         if (m == 10) check("t6_ready", 32'(cmd_ready), 1);
         if (m == 11) begin
            check("t6_cfg_rst_start", 32'(cnt_load_val), 0);
            check("t6_cfg_rst_dir", 32'(cnt_dir), 0);
         end
         if (m == 13) check("t6_stop", 32'(state), 0);
         nxt();
      end

      // 7: SAW_DOWN 6..3, psc 1.
      for (int n = 0; n <= 11; n++) begin
         int j;
         j = n - 2;
         idle();
         if (n == 0) drive(OP_UPD, 16'd3, 16'd6, 8'd1, 2'd1);
         if (n == 1) drive(OP_START, '0, '0, '0, '0);
         #1;
         if (j == 0) check("t7_load_val", 32'(cnt_load_val), 6);
         if (j >= 1 && j <= 9) begin
            check("t7_en", 32'(cnt_en), 32'(j == 2 || j == 4 || j == 6));
            check("t7_evt", 32'(end_evt), 32'(j == 8));
            check("t7_dir", 32'(cnt_dir), 1);
         end
         if (j == 6) check("t7_cnt4", 32'(cnt), 4);
         if (j == 8) begin
            check("t7_cnt3", 32'(cnt), 3);
            check("t7_wrap_val", 32'(cnt_load_val), 6);
         end
         nxt();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
